pipe_share_arb: RTL and testbench

//  Round-robin arbiter/scheduler that shares one fixed-latency pipelined fixed-point

---
 rtl/pipe_share_pkg.sv | 22 ++
 rtl/pipe_share_arb_if.sv | 28 ++
 rtl/pipe_share_arb_pipe_reg.sv | 22 ++
 rtl/pipe_share_arb.sv | 73 +++++++
 tb/tb_pipe_share_arb.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/pipe_share_pkg.sv
// pipe_share_pkg: shared types, default configuration and round-robin search for pipe_share_arb
package pipe_share_pkg;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_DW = 16;
  localparam int DEF_LAT = 2;
  localparam int DEF_MAX_OUT = 2;
  localparam int DEF_IDW = $clog2(DEF_N_REQ);
  localparam int DEF_CW = $clog2(DEF_MAX_OUT + 1);
  localparam int MAX_N = 32;
  typedef logic [DEF_IDW-1:0] id_t;
  typedef logic [DEF_CW-1:0] cnt_t;
  // First set bit of elig at or above ptr, wrapping modulo n; -1 when none.
  // Scanning downward lets the nearest candidate overwrite farther ones.
  function automatic int rr_pick(input logic [MAX_N-1:0] elig, input int ptr, input int n);
    int idx;
    rr_pick = -1;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      idx = ptr + k >= n ? ptr + k - n : ptr + k;
      if (k < n && elig[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/pipe_share_arb_if.sv
// pipe_share_arb_if: requester, datapath and result signals of pipe_share_arb
// Ports: slave = arbiter side (drives gnt, dp_*, res_*, busy); master = environment side.
interface pipe_share_arb_if
  import pipe_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DW = DEF_DW
);
  localparam int IDW = $clog2(N_REQ);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0][DW-1:0] req_data;
  logic dp_valid;
  logic [DW-1:0] dp_data;
  logic [DW-1:0] dp_result;
  logic res_valid;
  logic [IDW-1:0] res_id;
  logic [DW-1:0] res_data;
  logic busy;
  modport master (
    output req, req_data, dp_result,
    input gnt, dp_valid, dp_data, res_valid, res_id, res_data, busy
  );
  modport slave (
    input req, req_data, dp_result,
    output gnt, dp_valid, dp_data, res_valid, res_id, res_data, busy
  );
endinterface

// File: rtl/pipe_share_arb_pipe_reg.sv
// pipe_reg: STAGE-deep register delay line with async active-low reset
// Ports: clk, rst_n, d (input word), q (d delayed STAGE cycles).
module pipe_reg #(
  parameter int WIDTH = 1,
  parameter int STAGE = 1
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s [STAGE];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGE; k++) s[k] <= '0;
    end else begin
      s[0] <= d;
      for (int k = 1; k < STAGE; k++) s[k] <= s[k-1];
    end
  end
  assign q = s[STAGE-1];
endmodule

// File: rtl/pipe_share_arb.sv
// pipe_share_arb: round-robin sharing of one fixed-latency pipelined datapath among N_REQ requesters
// Ports: clk, rst_n (async active-low), flush (sync kill of all in-flight ops),
//        bus (slave): req/req_data/gnt requester side, dp_* datapath side,
//        res_valid/res_id/res_data tagged results, busy = any op in flight.
module pipe_share_arb
  import pipe_share_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DW = DEF_DW,
  parameter int LAT = DEF_LAT,
  parameter int MAX_OUT = DEF_MAX_OUT
)(
  input logic clk,
  input logic rst_n,
  input logic flush,
  pipe_share_arb_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_OUT + 1);
  logic [IDW-1:0] ptr, ptr_nxt, gnt_id, dp_id;
  logic [CW-1:0] cnt [N_REQ];
  logic [N_REQ-1:0] elig;
  logic [LAT-1:0] vld;
  logic grant, any_cnt;
  int pick;
  // Eligibility uses the registered counts only, so a same-cycle return cannot free a slot.
  always_comb begin
    any_cnt = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = bus.req[i] && cnt[i] < CW'(MAX_OUT);
      any_cnt = any_cnt | (cnt[i] != '0);
    end
    pick = rr_pick(MAX_N'(elig), int'(ptr), N_REQ);
    grant = rst_n && !flush && pick >= 0;
    gnt_id = IDW'(pick);
    ptr_nxt = gnt_id == IDW'(N_REQ - 1) ? '0 : gnt_id + IDW'(1);
    bus.gnt = grant ? N_REQ'(1) << gnt_id : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      bus.dp_valid <= 1'b0;
      bus.dp_data <= '0;
      dp_id <= '0;
      vld <= '0;
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      bus.dp_valid <= grant;
      if (grant) begin
        ptr <= ptr_nxt;
        bus.dp_data <= bus.req_data[gnt_id];
        dp_id <= gnt_id;
      end
      // Valid tag line: shift in dp_valid; flush empties it so killed ops never report.
      vld <= flush ? '0 : LAT'({vld, bus.dp_valid});
      for (int i = 0; i < N_REQ; i++)
        cnt[i] <= flush ? '0 : cnt[i] + CW'(bus.gnt[i]) - CW'(bus.res_valid && bus.res_id == IDW'(i));
    end
  end
  pipe_reg #(.WIDTH(IDW), .STAGE(LAT)) u_id (
    .clk(clk),
    .rst_n(rst_n),
    .d(dp_id),
    .q(bus.res_id)
  );
  assign bus.res_valid = vld[LAT-1];
  assign bus.res_data = bus.dp_result;
  assign bus.busy = bus.dp_valid | (|vld) | any_cnt;
  assert property (@(posedge clk) disable iff (!rst_n) bus.res_valid |-> cnt[bus.res_id] != '0);
  for (genvar g = 0; g < N_REQ; g++) begin : g_cap
    assert property (@(posedge clk) disable iff (!rst_n) cnt[g] <= CW'(MAX_OUT));
  end
endmodule

// File: tb/tb_pipe_share_arb.sv
// tb_pipe_share_arb: directed and random checks of pipe_share_arb against an in-flight-queue reference model
module tb_pipe_share_arb;
  import pipe_share_pkg::*;
  localparam int N = 4;
  localparam int DW = 16;
  localparam int LAT = 2;
  localparam int MO = 2;
  typedef struct {
    id_t id;
    logic [DW-1:0] res;
    int due;
  } op_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;
  pipe_share_arb_if #(.N_REQ(N), .DW(DW)) bus ();
  pipe_share_arb #(.N_REQ(N), .DW(DW), .LAT(LAT), .MAX_OUT(MO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(bus)
  );
  // Environment datapath: result = operand + 1, LAT cycles after dp_valid.
  logic [DW-1:0] dpq [LAT];
  always @(posedge clk) begin
    dpq[0] <= bus.dp_data + 16'd1;
    for (int k = 1; k < LAT; k++) dpq[k] <= dpq[k-1];
  end
  assign bus.dp_result = dpq[LAT-1];
  op_t q[$];
  int cyc = 0;
  int last = N - 1;
  int checks = 0;
  int fails = 0;
  logic prev_g = 1'b0;
  logic [DW-1:0] exp_dd = '0;
  logic use_fix = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int inflight(input int id);
    int n = 0;
    foreach (q[j]) if (int'(q[j].id) == id) n++;
    return n;
  endfunction
  task automatic reset_chk(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(0));
    chk({tag, "_dp_valid"}, 32'(bus.dp_valid), 32'(0));
    chk({tag, "_dp_data"}, 32'(bus.dp_data), 32'(0));
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'(0));
    chk({tag, "_res_id"}, 32'(bus.res_id), 32'(0));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
  endtask
  // One cycle: drive inputs, compare every output with the model, then advance the model.
  task automatic step(input logic [N-1:0] r, input logic f);
    logic [DW-1:0] drv [N];
    logic [N-1:0] eg;
    int gi;
    op_t o;
    @(negedge clk);
    bus.req = r;
    flush = f;
    for (int i = 0; i < N; i++) begin
      drv[i] = (use_fix && i == 1) ? 16'h1234 : DW'($urandom);
      bus.req_data[i] = drv[i];
    end
    #1;
    gi = -1;
    if (!f)
      for (int k = 0; k < N; k++) begin
        automatic int i = (last + 1 + k) % N;
        if (gi < 0 && r[i] && inflight(i) < MO) gi = i;
      end
    eg = '0;
    if (gi >= 0) eg[gi] = 1'b1;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("dp_valid", 32'(bus.dp_valid), 32'(prev_g));
    chk("dp_data", 32'(bus.dp_data), 32'(exp_dd));
    chk("busy", 32'(bus.busy), 32'(q.size() != 0));
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("res_valid", 32'(bus.res_valid), 32'(1));
      chk("res_id", 32'(bus.res_id), 32'(q[0].id));
      chk("res_data", 32'(bus.res_data), 32'(q[0].res));
      void'(q.pop_front());
    end else begin
      chk("res_valid", 32'(bus.res_valid), 32'(0));
    end
    prev_g = gi >= 0;
    if (gi >= 0) begin
      o.id = id_t'(gi);
      o.res = drv[gi] + 16'd1;
      o.due = cyc + LAT + 1;
      q.push_back(o);
      last = gi;
      exp_dd = drv[gi];
    end
    if (f) q.delete();
    cyc++;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0);
  endtask
  initial begin
    bus.req = '0;
    bus.req_data = '0;
    #22;
    reset_chk("por");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    for (int k = 0; k < 12; k++) step(4'b1111, 1'b0);
    idle(5);
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    @(negedge clk);
    #2;
    bus.req = '0;
    rst_n = 1'b0;
    #1;
    reset_chk("midrst");
    q.delete();
    last = N - 1;
    prev_g = 1'b0;
    exp_dd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) step(4'b1111, 1'b0);
    idle(5);
    for (int k = 0; k < 12; k++) step(4'b0100, 1'b0);
    idle(5);
    use_fix = 1'b1;
    step(4'b0010, 1'b0);
    use_fix = 1'b0;
    idle(5);
    for (int k = 0; k < 3; k++) step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    idle(4);
    step(4'b1111, 1'b0);
    idle(5);
    for (int k = 0; k < 12; k++) step(4'b0001, 1'b0);
    idle(5);
    for (int k = 0; k < 300; k++) step(N'($urandom), $urandom_range(0, 19) == 0);
    idle(6);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
